// File: rtl/cpu_trace_decoder_pkg.sv
// Shared definitions for the trace record decoder: FSM encodings, ASCII
// constants, error bit positions, record type codes and legal field ranges.
package cpu_trace_decoder_pkg;

    localparam logic [31:0] PC_LO   = 32'h0000_3000;
    localparam logic [31:0] PC_HI   = 32'h0000_4FFF;
    localparam logic [31:0] ADDR_HI = 32'h0000_2FFF;
    localparam logic [31:0] REG_MAX = 32'd31;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_TIME     = 4'd1,
        S_PC       = 4'd2,
        S_COLON_SP = 4'd3,
        S_REGN     = 4'd4,
        S_ADDR     = 4'd5,
        S_PRE_LT   = 4'd6,
        S_EQ       = 4'd7,
        S_POST_EQ  = 4'd8,
        S_DATA     = 4'd9,
        S_DONE     = 4'd10
    } state_t;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_LT     = 8'h3C;
    localparam logic [7:0] CH_EQ     = 8'h3D;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    localparam int ERR_TIME = 0;
    localparam int ERR_PC   = 1;
    localparam int ERR_ADDR = 2;
    localparam int ERR_REG  = 3;

    localparam logic [1:0] TYPE_NONE = 2'b00;
    localparam logic [1:0] TYPE_REG  = 2'b01;
    localparam logic [1:0] TYPE_MEM  = 2'b10;

    // Range checks on a finished record; bits that do not apply to the
    // record type stay 0.
    function automatic logic [3:0] calc_err(input logic        is_mem,
                                            input logic [13:0] t,
                                            input logic [31:0] pc,
                                            input logic [31:0] dest);
        logic [3:0] e;
        e = 4'b0000;
        e[ERR_TIME] = t[0];
        e[ERR_PC]   = (pc < PC_LO) || (pc > PC_HI) || (pc[1:0] != 2'b00);
        if (is_mem)
            e[ERR_ADDR] = (dest > ADDR_HI) || (dest[1:0] != 2'b00);
        else
            e[ERR_REG] = (dest > REG_MAX);
        return e;
    endfunction

endpackage

// File: rtl/cpu_trace_decoder_char_class.sv
// Character classifier: decimal digit, lowercase hex digit, and nibble value.
module cpu_trace_decoder_char_class (
    input  logic [7:0] char,
    output logic       is_dec,
    output logic       is_hex,
    output logic [3:0] nib
);

    logic is_af;

    // Classify the character and convert it to its 4-bit value
    always_comb begin
        is_dec = (char >= 8'h30) && (char <= 8'h39);
        is_af  = (char >= 8'h61) && (char <= 8'h66);
        is_hex = is_dec || is_af;
        nib    = 4'h0;
        if (is_dec)
            nib = char[3:0];
        else if (is_af)
            nib = char[3:0] + 4'd9;
    end

endmodule

// File: rtl/cpu_trace_decoder.sv
// Trace record decoder: parses reg/mem write records from an ASCII stream,
// converts the fields to binary and presents one checked record per '#'.
module cpu_trace_decoder
    import cpu_trace_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char,
    output logic        rec_valid,
    output logic [1:0]  rec_type,
    output logic [13:0] rec_time,
    output logic [31:0] rec_pc,
    output logic [31:0] rec_dest,
    output logic [31:0] rec_data,
    output logic [3:0]  err_code
);

    state_t      state, next_state;
    logic [3:0]  cnt;
    logic        is_dec, is_hex;
    logic [3:0]  nib;
    logic [13:0] time_acc;
    logic [31:0] pc_acc, dest_acc, data_acc;
    logic        is_mem;

    cpu_trace_decoder_char_class u_class (
        .char   (char),
        .is_dec (is_dec),
        .is_hex (is_hex),
        .nib    (nib)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state decode: any character not explicitly allowed falls back to IDLE
    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE:     if (char == CH_CARET) next_state = S_TIME;
            S_TIME:     if (is_dec && cnt < 4'd4) next_state = S_TIME;
                        else if (char == CH_AT && cnt != 4'd0) next_state = S_PC;
            S_PC:       if (is_hex && cnt < 4'd8) next_state = S_PC;
                        else if (char == CH_COLON && cnt == 4'd8) next_state = S_COLON_SP;
            S_COLON_SP: if (char == CH_SPACE) next_state = S_COLON_SP;
                        else if (char == CH_DOLLAR) next_state = S_REGN;
                        else if (char == CH_STAR) next_state = S_ADDR;
            S_REGN:     if (is_dec && cnt < 4'd4) next_state = S_REGN;
                        else if (cnt != 4'd0 && char == CH_SPACE) next_state = S_PRE_LT;
                        else if (cnt != 4'd0 && char == CH_LT) next_state = S_EQ;
            S_ADDR:     if (is_hex && cnt < 4'd8) next_state = S_ADDR;
                        else if (cnt == 4'd8 && char == CH_SPACE) next_state = S_PRE_LT;
                        else if (cnt == 4'd8 && char == CH_LT) next_state = S_EQ;
            S_PRE_LT:   if (char == CH_SPACE) next_state = S_PRE_LT;
                        else if (char == CH_LT) next_state = S_EQ;
            S_EQ:       if (char == CH_EQ) next_state = S_POST_EQ;
            S_POST_EQ:  if (char == CH_SPACE) next_state = S_POST_EQ;
                        else if (is_hex) next_state = S_DATA;
            S_DATA:     if (is_hex && cnt < 4'd8) next_state = S_DATA;
                        else if (char == CH_HASH && cnt == 4'd8) next_state = S_DONE;
            S_DONE:     if (char == CH_CARET) next_state = S_TIME;
            default:    next_state = S_IDLE;
        endcase
    end

    // Output decode: the pulse is exactly the single cycle spent in DONE
    always_comb begin
        rec_valid = (state == S_DONE);
    end

    // Field counter and shadow accumulators; a field clears on its entry char
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= 4'd0;
            time_acc <= 14'd0;
            pc_acc   <= 32'd0;
            dest_acc <= 32'd0;
            data_acc <= 32'd0;
            is_mem   <= 1'b0;
        end else begin
            if (next_state != state)
                cnt <= (next_state == S_DATA) ? 4'd1 : 4'd0;
            else if (state inside {S_TIME, S_PC, S_REGN, S_ADDR, S_DATA})
                cnt <= cnt + 4'd1;

            if (next_state == S_TIME)
                time_acc <= (state == S_TIME) ? time_acc * 14'd10 + {10'd0, nib} : 14'd0;
            if (next_state == S_PC)
                pc_acc <= (state == S_PC) ? {pc_acc[27:0], nib} : 32'd0;
            if (next_state == S_REGN) begin
                dest_acc <= (state == S_REGN) ?
                            {18'd0, dest_acc[13:0] * 14'd10 + {10'd0, nib}} : 32'd0;
                is_mem   <= 1'b0;
            end
            if (next_state == S_ADDR) begin
                dest_acc <= (state == S_ADDR) ? {dest_acc[27:0], nib} : 32'd0;
                is_mem   <= 1'b1;
            end
            if (next_state == S_DATA)
                data_acc <= (state == S_DATA) ? {data_acc[27:0], nib} : {28'd0, nib};
        end
    end

    // Output registers: load from the shadows only on the '#' that completes a record
    always_ff @(posedge clk) begin
        if (reset) begin
            rec_type <= TYPE_NONE;
            rec_time <= 14'd0;
            rec_pc   <= 32'd0;
            rec_dest <= 32'd0;
            rec_data <= 32'd0;
            err_code <= 4'd0;
        end else if (state == S_DATA && next_state == S_DONE) begin
            rec_type <= is_mem ? TYPE_MEM : TYPE_REG;
            rec_time <= time_acc;
            rec_pc   <= pc_acc;
            rec_dest <= dest_acc;
            rec_data <= data_acc;
            err_code <= calc_err(is_mem, time_acc, pc_acc, dest_acc);
        end
    end

endmodule

// File: tb/tb_cpu_trace_decoder.sv
// Directed bench for cpu_trace_decoder.
module tb_cpu_trace_decoder;

    logic        clk;
    logic        reset;
    logic [7:0]  char;
    logic        rec_valid;
    logic [1:0]  rec_type;
    logic [13:0] rec_time;
    logic [31:0] rec_pc;
    logic [31:0] rec_dest;
    logic [31:0] rec_data;
    logic [3:0]  err_code;

    int checks   = 0;
    int failures = 0;
    int char_idx = 0;
    int pulses   = 0;
    int pulse_q[$];
    int p0;

    cpu_trace_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .char      (char),
        .rec_valid (rec_valid),
        .rec_type  (rec_type),
        .rec_time  (rec_time),
        .rec_pc    (rec_pc),
        .rec_dest  (rec_dest),
        .rec_data  (rec_data),
        .err_code  (err_code)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one char at a negedge; observe the result at the next negedge.
    task automatic send_char(input logic [7:0] c);
        char = c;
        @(negedge clk);
        char_idx++;
        if (rec_valid === 1'b1) begin
            pulses++;
            pulse_q.push_back(char_idx);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_char(s[i]);
    endtask

    task automatic check_rec(input string tag, input logic [1:0] t, input logic [13:0] tm,
                             input logic [31:0] pc, input logic [31:0] dest,
                             input logic [31:0] data, input logic [3:0] err);
        check({tag, "_type"}, {30'd0, rec_type}, {30'd0, t});
        check({tag, "_time"}, {18'd0, rec_time}, {18'd0, tm});
        check({tag, "_pc"},   rec_pc, pc);
        check({tag, "_dest"}, rec_dest, dest);
        check({tag, "_data"}, rec_data, data);
        check({tag, "_err"},  {28'd0, err_code}, {28'd0, err});
    endtask

    initial begin
        reset = 1'b1;
        char  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset state
        check("rst_valid", {31'd0, rec_valid}, 32'd0);
        check_rec("rst", 2'b00, 14'd0, 32'd0, 32'd0, 32'd0, 4'b0000);

        // 1: register write
        p0 = pulses;
        send_str("^10@00003000: $1 <= 0000000f#");
        check("t1_pulse", pulses - p0, 1);
        check_rec("t1", 2'b01, 14'd10, 32'h3000, 32'd1, 32'h0000000f, 4'b0000);
        send_str("  ");

        // 2: memory write with irregular spacing
        p0 = pulses;
        send_str("^2@00003004:  *00000010<=  deadbeef#");
        check("t2_pulse", pulses - p0, 1);
        check_rec("t2", 2'b10, 14'd2, 32'h3004, 32'h10, 32'hdeadbeef, 4'b0000);
        send_str(" ");

        // 3: error flags
        send_str("^7@00002ffe: $40 <= 00000000#");
        check_rec("t3a", 2'b01, 14'd7, 32'h2ffe, 32'd40, 32'd0, 4'b1011);
        send_str(" ");
        send_str("^4@00005000: *00002ffc <= 00000000#");
        check_rec("t3b", 2'b10, 14'd4, 32'h5000, 32'h2ffc, 32'd0, 4'b0010);
        send_str(" ");
        send_str("^4@00003000: *00003001 <= 00000000#");
        check_rec("t3c", 2'b10, 14'd4, 32'h3000, 32'h3001, 32'd0, 4'b0100);
        send_str(" ");

        // 4: malformed records never pulse and never touch the outputs
        p0 = pulses;
        send_str("^12345@00003000: $1 <= 00000001# ");
        send_str("^1@0000300: $1 <= 00000001# ");
        send_str("^2@00003000: *0000300 <= 00000001# ");
        send_str("^2@00003000: $1 < = 00000001# ");
        send_str("^2@00003000: $1 <= 0000000A# ");
        send_str("^2@000^2@00003000: $1 <= 00000001# ");
        check("t4_nopulse", pulses - p0, 0);
        check_rec("t4_hold", 2'b10, 14'd4, 32'h3000, 32'h3001, 32'd0, 4'b0100);
        send_str("^6@00003ffc: *00000ffc <= 12345678#");
        check("t4_pulse", pulses - p0, 1);
        check_rec("t4v", 2'b10, 14'd6, 32'h3ffc, 32'h0ffc, 32'h12345678, 4'b0000);
        send_str(" ");

        // 5: back-to-back records
        p0 = pulses;
        send_str("^9999@00004ffc: $31 <= ffffffff#");
        check_rec("t5a", 2'b01, 14'd9999, 32'h4ffc, 32'd31, 32'hffffffff, 4'b0001);
        send_str("^8@00003008: $0 <= 00000001#");
        check("t5_pulses", pulses - p0, 2);
        if (pulse_q.size() >= 2)
            check("t5_gap", pulse_q[pulse_q.size()-1] - pulse_q[pulse_q.size()-2], 28);
        else
            check("t5_gap_missing", pulse_q.size(), 2);
        check_rec("t5b", 2'b01, 14'd8, 32'h3008, 32'd0, 32'd1, 4'b0000);
        send_str(" ");

        // 6: reset mid-DATA
        p0 = pulses;
        send_str("^3@00003000: $2 <= 1234");
        reset = 1'b1;
        send_char("5");
        reset = 1'b0;
        send_str("678# ");
        check("t6_nopulse", pulses - p0, 0);
        check_rec("t6_zero", 2'b00, 14'd0, 32'd0, 32'd0, 32'd0, 4'b0000);
        send_str("^12@00003010: *00000004 <= cafef00d#");
        check("t6_pulse", pulses - p0, 1);
        check_rec("t6v", 2'b10, 14'd12, 32'h3010, 32'h4, 32'hcafef00d, 4'b0000);
        send_str("  ");
        check("t6_pulse_once", pulses - p0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
